// File: rtl/rr_arbiter_2x4.sv
// Round-robin arbiter: four requesters, held grants, one idle cycle between owners.
// Optional HOLD_LIMIT_EN caps each grant at MAX_HOLD cycles.
module rr_arbiter_2x4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [0:3] req,
  output logic [0:3] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);
  localparam int   NUM_REQ = 4;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter_2x4: MAX_HOLD must be in 2..255");
  end

  logic       state;
  logic [1:0] ptr;
  logic [1:0] win;
  logic       found;
  logic [0:3] dec;
  logic       hold_expire;
  logic       release_now;

  // Scan from the farthest offset down so the one closest to ptr wins.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        win   = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_dec
    assign dec[i] = (win == 2'(i));
  end

`ifdef HOLD_LIMIT_EN
  logic [7:0] hold_cnt;

  // Zero while idle, so every new grant starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) hold_cnt <= '0;
    else                         hold_cnt <= hold_cnt + 8'd1;
  end

  assign hold_expire = (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign hold_expire = 1'b0;
`endif

  assign release_now = !en || !req[gnt_id] || hold_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
    end else if (state == ST_IDLE) begin
      if (en && found) begin
        gnt    <= dec;
        gnt_id <= win;
        state  <= ST_BUSY;
      end
    end else if (release_now) begin
      // Release, revoke and forced release all hand priority past the owner.
      gnt   <= '0;
      state <= ST_IDLE;
      ptr   <= gnt_id + 2'd1;
    end
  end

  assign gnt_valid = |gnt;
endmodule

// File: tb/tb_rr_arbiter_2x4.sv
// Bench for rr_arbiter_2x4: directed scenarios plus random traffic, scored against
// an owner/pointer model through an expectation queue.
module tb_rr_arbiter_2x4;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [0:3] req;
  logic [0:3] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  rr_arbiter_2x4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:3] g;
    logic [1:0] id;
    logic       v;
    bit         chk_id;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the resource, where priority starts, how long held.
  int owner = -1;
  int ptr_m = 0;
  int held  = 0;

  task automatic model_step(input logic [0:3] r, input logic e, input logic rs);
    exp_t x;
    if (rs) begin
      owner = -1; ptr_m = 0; held = 0;
    end else if (owner >= 0) begin
`ifdef HOLD_LIMIT_EN
      if (!e || !r[owner] || held == MAX_HOLD - 1) begin
`else
      if (!e || !r[owner]) begin
`endif
        ptr_m = (owner + 1) % 4;
        owner = -1;
      end else held++;
    end else if (e) begin
      for (int k = 0; k < 4; k++)
        if (owner < 0 && r[(ptr_m + k) % 4]) owner = (ptr_m + k) % 4;
      held = 0;
    end
    x.g = '0;
    if (owner >= 0) x.g[owner] = 1'b1;
    x.v      = (owner >= 0);
    x.id     = (owner >= 0) ? 2'(owner) : 2'd0;
    x.chk_id = (owner >= 0) || rs;
    exp_q.push_back(x);
  endtask

  task automatic cycle(input logic [0:3] r, input logic e = 1'b1, input logic rs = 1'b0);
    @(negedge clk);
    req = r; en = e; rst = rs;
    @(posedge clk);
    model_step(r, e, rs);
  endtask

  // Literal expectation for the directed scenarios, sampled just after the edge.
  task automatic chk(input string nm, input logic [0:3] eg, input logic [1:0] eid = 2'd0);
    #2;
    tests++;
    if (gnt !== eg || gnt_valid !== (|eg) || ((|eg) && gnt_id !== eid)) begin
      fails++;
      $display("FAIL %s: gnt=%b id=%0d valid=%b, required gnt=%b id=%0d valid=%b",
               nm, gnt, gnt_id, gnt_valid, eg, eid, |eg);
    end
  endtask

  // Monitor: scores every cycle against the queue plus structural rules.
  exp_t       me;
  logic [0:3] prev_g = '0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      tests++;
      if (gnt !== me.g || gnt_valid !== me.v || (me.chk_id && gnt_id !== me.id)) begin
        fails++;
        $display("FAIL scoreboard @%0t: gnt=%b id=%0d valid=%b, required gnt=%b id=%0d valid=%b",
                 $time, gnt, gnt_id, gnt_valid, me.g, me.id, me.v);
      end
      tests++;
      if ($countones(gnt) > 1 || (prev_g != 0 && gnt != 0 && prev_g != gnt)) begin
        fails++;
        $display("FAIL onehot_gap @%0t: gnt=%b after %b, required one-hot/zero with idle gap",
                 $time, gnt, prev_g);
      end
      prev_g = gnt;
    end
  end

  initial begin
    logic [0:3] e4, r4;
    rst = 1'b1; en = 1'b0; req = '0;
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("reset", 4'b0000);
    tests++;
    if (gnt_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_id: gnt_id=%0d, required 0", gnt_id);
    end

    // Single requester 2, release sets ptr=3.
    cycle(4'b0010); chk("grant2", 4'b0010, 2'd2);
    cycle(4'b0010); chk("hold2", 4'b0010, 2'd2);
    cycle(4'b0000); chk("release2", 4'b0000);
    cycle(4'b1001); chk("ptr3_wins", 4'b0001, 2'd3);
    cycle(4'b1001); chk("hold3", 4'b0001, 2'd3);
    cycle(4'b1000); chk("release3", 4'b0000);

    // All four requesting: ptr wrapped to 0, order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      e4 = '0; e4[i % 4] = 1'b1;
      cycle(4'b1111); chk("rr_order", e4, 2'(i % 4));
      cycle(4'b1111); chk("rr_hold", e4, 2'(i % 4));
      cycle(4'b1111 & ~e4); chk("rr_gap", 4'b0000);
    end

    // ptr=1: revoke requester 1 with en=0, then ptr=2 scan wraps to 0.
    cycle(4'b0100); chk("grant1", 4'b0100, 2'd1);
    cycle(4'b0100, 1'b0); chk("revoke", 4'b0000);
    cycle(4'b1100); chk("wrap_to0", 4'b1000, 2'd0);
    cycle(4'b0000); chk("release0", 4'b0000);

    // ptr=1: requester 3 granted, reset mid-grant.
    cycle(4'b0001); chk("grant3", 4'b0001, 2'd3);
    cycle(4'b0001, 1'b1, 1'b1); chk("rst_busy", 4'b0000);
    tests++;
    if (gnt_id !== 2'd0) begin
      fails++;
      $display("FAIL rst_busy_id: gnt_id=%0d, required 0", gnt_id);
    end
    cycle(4'b1111); chk("after_rst", 4'b1000, 2'd0);
    cycle(4'b0111); chk("release_after_rst", 4'b0000);

    // en=0 in IDLE: nothing granted, ptr stays 1.
    cycle(4'b1111, 1'b0); chk("en0_idle", 4'b0000);
    cycle(4'b1111, 1'b0); chk("en0_idle2", 4'b0000);
    cycle(4'b1110); chk("ptr_kept", 4'b0100, 2'd1);
    cycle(4'b0000); chk("release1", 4'b0000);

    // One-cycle pulse from requester 2 (ptr=2).
    cycle(4'b0010); chk("pulse_grant", 4'b0010, 2'd2);
    cycle(4'b0000); chk("pulse_drop", 4'b0000);

    // Long hold by requester 0 (ptr=3 scan wraps to 0).
    cycle(4'b1000); chk("long_grant", 4'b1000, 2'd0);
    for (int i = 0; i < 100; i++) begin
      cycle(4'b1000);
`ifndef HOLD_LIMIT_EN
      if (i % 25 == 24) chk("long_hold", 4'b1000, 2'd0);
`endif
    end
    cycle(4'b0000);

    // Random traffic scored by the monitor only.
    for (int i = 0; i < 600; i++) begin
      r4 = 4'($urandom);
      cycle(r4, $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0);
    end

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_2x4.md
Name: rr_arbiter_2x4

Overview:
- Round-robin arbiter that shares one resource among four requesters.
- Internally it selects a 2-bit winner index. The registered grant vector is the one-hot decode of that index, using the MSB-first convention: bit [0] is requester 0 and is the MSB.
- It sits in front of a shared resource (bus port, memory bank) and drives its select lines.
- Grants are held until the owner releases them. Fairness comes from a rotating priority pointer.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant. Used only when HOLD_LIMIT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable. 0 blocks new grants and revokes the current grant.
- req  input  [0:3]  request vector. req[0] is requester 0 (MSB), req[3] is requester 3 (LSB).
- gnt  output  [0:3]  registered one-hot grant. Same index convention as req. Value is 4'b0000 when idle.
- gnt_id  output  [1:0]  binary index of the current owner. Valid only when gnt_valid=1.
- gnt_valid  output  1  1 while any grant is asserted (equals OR of gnt).

Behaviour:
- Reset values, on the rst=1 clock edge:
  - state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0.
  - Priority pointer ptr=2'b00.
  - rst has priority over every other input.
- State IDLE (gnt=0):
  - If en=1 and any req bit is set, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register the result: gnt=decode(winner), gnt_id=winner, gnt_valid=1. Go to BUSY.
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge N gives gnt visible after edge N (one cycle).
- State BUSY:
  - Grant is held as long as req[gnt_id]=1 and en=1. Changes on other req bits are ignored.
  - Release happens when req[gnt_id]=0 at a clock edge. On that edge: gnt=0, gnt_valid=0, state goes to IDLE, ptr=gnt_id+1 (mod 4, so 3 wraps to 0).
  - Revoke happens when en=0 at a clock edge. Actions are the same as release. ptr is also advanced, so a revoked owner loses priority.
- Handover gap:
  - At least one idle cycle always separates two grants (the IDLE cycle).
  - There is never a cycle where two gnt bits are set, and never a direct owner-to-owner switch.
- Decode rule for gnt: 00 gives 1000, 01 gives 0100, 10 gives 0010, 11 gives 0001.
  - gnt is always exactly one-hot or all-zero.
- Boundary cases:
  - All four requesting continuously: grants go 0,1,2,3,0,... with one gap cycle between each.
  - Requester 3 releases: ptr wraps to 0.
  - A single requester drops and immediately re-raises its request: it wins again only if no other requester is pending at or after ptr.
  - req pulse lasting one cycle in IDLE: it is granted. If req is already 0 at the next edge, the grant lasts exactly one cycle.
  - en=0 in IDLE: no grant, ptr unchanged.
  - rst during BUSY: grant drops on the same edge and ptr returns to 0.

Optional Feature:
- Macro HOLD_LIMIT_EN.
- When defined:
  - An 8-bit hold counter clears on each new grant and increments every BUSY cycle.
  - When the counter reaches MAX_HOLD-1 while in BUSY, the next edge forces a release even if req[gnt_id]=1. ptr advances past the owner.
  - The same owner may be re-granted later through normal round-robin.
- When not defined:
  - No counter is built. Grants are held indefinitely while the owner requests and en=1.

Test Plan:
- Reset, then req=4'b0010, en=1.
  - Expected: gnt=4'b0010 and gnt_id=2 one cycle later.
  - After req=0: gnt=0 next cycle, and ptr=3 (checked by a following req=4'b1001, which must grant requester 3, gnt=4'b0001).
- req=4'b1111 held, en=1, grant held 2 cycles each by dropping the owner's bit then restoring it.
  - Expected: grant order 0,1,2,3,0, with gnt=0 for exactly one cycle between grants and never two bits set.
- Requester 1 granted, then en=0 for 1 cycle while req=4'b0100 stays high.
  - Expected: gnt=0 on the next edge.
  - With en=1 again and req=4'b1100: requester 0 wins (ptr=2 has no request, so the scan wraps to 0).
- rst=1 asserted mid-grant (gnt=4'b0001).
  - Expected: gnt=0, gnt_valid=0, gnt_id=0 at that edge.
  - Then req=4'b1111 grants requester 0.
- With HOLD_LIMIT_EN defined and MAX_HOLD=4, req=4'b1000 held.
  - Expected: gnt=4'b1000 for exactly 4 cycles, 1 idle cycle, then re-granted.
  - With req=4'b1100 held: alternates 0,1 every 4 cycles.
- Without the macro, req=4'b1000 held 100 cycles.
  - Expected: gnt stays 4'b1000 throughout.
